xswitch_out_sink: RTL and testbench
===================================

Name: xswitch_out_sink

Overview:
- Receiving end of one xswitch output (upstream) port.
- Samples valid_out/addr_out/data_out from the switch and answers with data_rd one cycle later when it can accept.
- Buffers accepted packets ({source, data}) in a small show-ahead FIFO for a local consumer.
- One instance per output port. Used as the bench/system responder the switch hands packets to.

Parameters:
- DATA_W, 8, width of data_out and the buffered payload
- ADDR_W, 2, width of addr_out (source port index)
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- valid_out  in  1  switch offers a packet this cycle
- addr_out  in  ADDR_W  source port of the offered packet
- data_out  in  DATA_W  payload of the offered packet
- data_rd  out  1  acknowledge, registered, one cycle after an accepted offer
- pkt_valid  out  1  FIFO head valid
- pkt_src  out  ADDR_W  FIFO head source port
- pkt_data  out  DATA_W  FIFO head payload
- pkt_ready  in  1  consumer pops the head when pkt_valid is also high
- flush  in  1  synchronous FIFO clear
- stats_clr  in  1  synchronous counter clear
- acc_cnt  out  4*CNT_W  accepted packets per source; slice i counts source i
- stall_cnt  out  CNT_W  offers refused

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, state IDLE, data_rd=0, pkt_valid=0, pkt_src=0, pkt_data=0, all counters 0.
- Internal signals:
  - pop = pkt_valid && pkt_ready
  - can_accept = (count < DEPTH) || pop
- FSM (IDLE, ACK, STALL), evaluated at every posedge:
  - flush=1 → IDLE. No write into the FIFO.
  - else valid_out && can_accept → write {addr_out, data_out} at wr_ptr, go to ACK.
  - else valid_out → STALL.
  - else → IDLE.
- data_rd = (state==ACK), so it is registered. Latency from the accepted offer edge to data_rd high is exactly 1 cycle.
- Back-to-back offers: each cycle with valid_out=1 is a distinct offer. Consecutive accepted offers hold data_rd high continuously.
- A refused offer is the switch's responsibility to re-present; the sink keeps no memory of it.
- FIFO, show-ahead:
  - pkt_* reflects the head entry combinationally from storage; pkt_valid = (count != 0).
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: allowed when full (count stays DEPTH) and when empty. When empty, nothing is popped, because pkt_valid=0 implies pop=0; count goes 0→1.
- Flush:
  - Clears pointers and count in one cycle. flush has priority over push and pop.
  - data_rd is 0 the following cycle.
  - Counters are not affected.
- Statistics:
  - On each accepted push, acc_cnt[addr_out] increments.
  - On each STALL entry, stall_cnt increments.
  - Counters saturate at all-ones.
  - stats_clr zeroes them. When clear and increment coincide, clear wins.
- Reset asserted mid-transfer: the pending data_rd is dropped immediately (asynchronous); FIFO contents are lost.

Optional Feature:
- Macro: XSW_SINK_PARITY_EN.
- When defined:
  - Adds input data_par (1 bit, even parity over data_out) and output par_err (1 bit, registered).
  - An offer with a parity mismatch is still accepted if there is room. par_err pulses for one cycle aligned with data_rd.
  - Adds output par_err_cnt (CNT_W), which saturates and is cleared by stats_clr.
- When undefined: these ports do not exist; no parity logic.

Decomposition:
- Package xswitch_sink_pkg holds:
  - typedef sink_state_e (IDLE, ACK, STALL)
  - typedef sink_entry_t packed {src, data}
  - constant NUM_PORTS=4
- One sub-module, xswitch_sink_fifo: a parameterised show-ahead FIFO with push/pop/flush, count, full/empty.
- FSM and counters stay in the top level.

Test Plan:
- Offer valid_out=1, addr_out=2, data_out=8'hA5 for one cycle into an empty sink → data_rd=1 on the next cycle only; pkt_valid=1, pkt_src=2, pkt_data=8'hA5; acc_cnt[2]=1.
- With pkt_ready=0, offer 5 back-to-back packets (data 1..5, DEPTH=4):
  - data_rd is high for 4 cycles, then low.
  - stall_cnt=1; FIFO holds 1..4.
  - Pop order 1,2,3,4.
- FIFO full with pkt_ready=1 and an offer of data 8'h77 in the same cycle → accepted with data_rd=1; count stays 4; 8'h77 emerges after the 3 older entries.
- Three entries queued, then flush=1 with a simultaneous offer → data_rd=0 next cycle, pkt_valid=0, acc_cnt unchanged by the dropped offer.
- Force acc_cnt[0] to all-ones, then accept a source-0 packet → stays all-ones. Assert stats_clr with a simultaneous accept → counter reads 0.
- Drop reset_n low mid-cycle while in ACK → data_rd and pkt_valid fall immediately without waiting for a clock edge. After release, the first offer behaves as in the first scenario.

Source files
------------

// File: rtl/xswitch_sink_pkg.sv
// ---------------------------------------------------------------------------
// xswitch_sink_pkg
// Shared types and constants for the xswitch output sink.
//   sink_state_e : acknowledge FSM states (IDLE, ACK, STALL)
//   sink_entry_t : buffered packet layout {src, data} at the default widths
//   NUM_PORTS    : number of switch source ports tracked by the statistics
// Optional feature macro used by the block: XSW_SINK_PARITY_EN
// ---------------------------------------------------------------------------
package xswitch_sink_pkg;

    localparam int unsigned NUM_PORTS   = 4;
    localparam int unsigned SINK_DATA_W = 8;
    localparam int unsigned SINK_ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        STALL = 2'd2
    } sink_state_e;

    // Default-width view of one FIFO entry; the parameterised top packs
    // the same {src, data} ordering into a flat vector.
    typedef struct packed {
        logic [SINK_ADDR_W-1:0] src;
        logic [SINK_DATA_W-1:0] data;
    } sink_entry_t;

endpackage

// File: rtl/xswitch_out_sink_if.sv
// ---------------------------------------------------------------------------
// xswitch_out_sink_if
// Handshake bundle between one xswitch output port and its sink.
//   valid_out : switch offers a packet this cycle
//   addr_out  : source port of the offered packet
//   data_out  : payload of the offered packet
//   data_rd   : sink acknowledge, one cycle after an accepted offer
//   data_par  : even parity over data_out   (XSW_SINK_PARITY_EN only)
//   par_err   : parity mismatch, with data_rd (XSW_SINK_PARITY_EN only)
// modport master : switch side; modport slave : sink side
// ---------------------------------------------------------------------------
interface xswitch_out_sink_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
);
    logic              valid_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_rd;
`ifdef XSW_SINK_PARITY_EN
    logic              data_par;
    logic              par_err;
`endif

`ifdef XSW_SINK_PARITY_EN
    modport master (output valid_out, addr_out, data_out, data_par,
                    input  data_rd, par_err);
    modport slave  (input  valid_out, addr_out, data_out, data_par,
                    output data_rd, par_err);
`else
    modport master (output valid_out, addr_out, data_out,
                    input  data_rd);
    modport slave  (input  valid_out, addr_out, data_out,
                    output data_rd);
`endif

endinterface

// File: rtl/xswitch_sink_fifo.sv
// ---------------------------------------------------------------------------
// xswitch_sink_fifo
// Show-ahead FIFO: rdata always presents the head entry from storage.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write request and data (ignored when full without pop)
//   pop          : remove head (ignored when empty)
//   flush        : clear pointers and count; overrides push and pop
//   rdata        : head entry
//   count        : occupancy, 0..DEPTH
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module xswitch_sink_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty && !flush;
        // A pop in the same cycle frees the slot the write lands in.
        do_push  = push && !flush && (!full || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/xswitch_out_sink.sv
// ---------------------------------------------------------------------------
// xswitch_out_sink
// Receiving end of one xswitch output port. Accepts offers when the local
// FIFO has room (or is being popped), acknowledges with a registered
// data_rd one cycle later, buffers {source, data} for a local consumer and
// keeps per-source accept and refused-offer statistics.
//   clk, reset_n : clock, asynchronous active-low reset
//   sw           : switch handshake (xswitch_out_sink_if.slave)
//   pkt_valid/pkt_src/pkt_data/pkt_ready : show-ahead consumer port
//   flush        : synchronous FIFO clear (counters untouched)
//   stats_clr    : synchronous statistics clear, wins over increments
//   acc_cnt      : accepted packets per source, slice i = source i
//   stall_cnt    : refused offers
//   par_err_cnt  : parity-error offers (XSW_SINK_PARITY_EN only)
// Optional feature macro: XSW_SINK_PARITY_EN
// ---------------------------------------------------------------------------
module xswitch_out_sink
    import xswitch_sink_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    xswitch_out_sink_if.slave          sw,
    output logic                       pkt_valid,
    output logic [ADDR_W-1:0]          pkt_src,
    output logic [DATA_W-1:0]          pkt_data,
    input  logic                       pkt_ready,
    input  logic                       flush,
    input  logic                       stats_clr,
    output logic [NUM_PORTS*CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0]           stall_cnt
`ifdef XSW_SINK_PARITY_EN
    ,
    output logic [CNT_W-1:0]           par_err_cnt
`endif
);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    sink_state_e                       state_q, state_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]                  stall_q, stall_d;

    logic                              pop;
    logic                              can_accept;
    logic                              accept;
    logic                              refuse;
    logic [ENTRY_W-1:0]                fifo_rdata;
    logic [$clog2(DEPTH):0]            fifo_count;
    logic                              fifo_full;
    logic                              unused_fifo_empty;

    xswitch_sink_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .wdata   ({sw.addr_out, sw.data_out}),
        .pop     (pop),
        .flush   (flush),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (unused_fifo_empty)
    );

    assign pkt_valid = (fifo_count != '0);
    assign pkt_src   = fifo_rdata[ENTRY_W-1:DATA_W];
    assign pkt_data  = fifo_rdata[DATA_W-1:0];

    assign pop        = pkt_valid && pkt_ready;
    assign can_accept = !fifo_full || pop;
    assign accept     = !flush && sw.valid_out && can_accept;
    assign refuse     = !flush && sw.valid_out && !can_accept;

    assign sw.data_rd = (state_q == ACK);
    assign acc_cnt    = acc_q;
    assign stall_cnt  = stall_q;

    always_comb begin
        state_d = IDLE;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = ACK;
        end else if (sw.valid_out) begin
            state_d = STALL;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        stall_d = stall_q;
        if (stats_clr) begin
            acc_d   = '0;
            stall_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (accept && (32'(sw.addr_out) == i) && (acc_q[i] != '1)) begin
                    acc_d[i] = acc_q[i] + CNT_W'(1);
                end
            end
            if (refuse && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            stall_q <= stall_d;
        end
    end

`ifdef XSW_SINK_PARITY_EN
    logic             par_err_q, par_err_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic             par_mis;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_mis     = ^{sw.data_out, sw.data_par};
    assign sw.par_err  = par_err_q;
    assign par_err_cnt = par_cnt_q;

    always_comb begin
        par_err_d = accept && par_mis;
        par_cnt_d = par_cnt_q;
        if (stats_clr) begin
            par_cnt_d = '0;
        end else if (accept && par_mis && (par_cnt_q != '1)) begin
            par_cnt_d = par_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
            par_cnt_q <= '0;
        end else begin
            par_err_q <= par_err_d;
            par_cnt_q <= par_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_xswitch_out_sink.sv
// ---------------------------------------------------------------------------
// tb_xswitch_out_sink
// Directed bench for xswitch_out_sink with CNT_W=4 so counter saturation is
// reachable in a few cycles. Inputs change 1 time unit after posedge and
// outputs are checked at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_xswitch_out_sink;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pkt_valid;
    logic [AW-1:0] pkt_src;
    logic [DW-1:0] pkt_data;
    logic          pkt_ready;
    logic          flush;
    logic          stats_clr;
    logic [4*CW-1:0] acc_cnt;
    logic [CW-1:0] stall_cnt;
`ifdef XSW_SINK_PARITY_EN
    logic [CW-1:0] par_err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    xswitch_out_sink_if #(.DATA_W(DW), .ADDR_W(AW)) sw_if ();

    xswitch_out_sink #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (4),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw        (sw_if),
        .pkt_valid (pkt_valid),
        .pkt_src   (pkt_src),
        .pkt_data  (pkt_data),
        .pkt_ready (pkt_ready),
        .flush     (flush),
        .stats_clr (stats_clr),
        .acc_cnt   (acc_cnt),
        .stall_cnt (stall_cnt)
`ifdef XSW_SINK_PARITY_EN
        ,
        .par_err_cnt (par_err_cnt)
`endif
    );

    always #5 clk = ~clk;

`ifdef XSW_SINK_PARITY_EN
    assign sw_if.data_par = ^sw_if.data_out;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] acc(input int i);
        return acc_cnt[i*CW +: CW];
    endfunction

    task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sw_if.valid_out = 1'b1;
        sw_if.addr_out  = a;
        sw_if.data_out  = d;
    endtask

    initial begin
        reset_n         = 1'b0;
        sw_if.valid_out = 1'b0;
        sw_if.addr_out  = '0;
        sw_if.data_out  = '0;
        pkt_ready       = 1'b0;
        flush           = 1'b0;
        stats_clr       = 1'b0;
        tick();
        tick();
        check("rst_data_rd",   32'(sw_if.data_rd), 32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_pkt_src",   32'(pkt_src), 32'd0);
        check("rst_pkt_data",  32'(pkt_data), 32'd0);
        check("rst_acc",       32'(acc_cnt), 32'd0);
        check("rst_stall",     32'(stall_cnt), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single offer into an empty sink
        offer(2'd2, 8'hA5);
        tick();
        sw_if.valid_out = 1'b0;
        check("s1_data_rd",   32'(sw_if.data_rd), 32'd1);
        check("s1_pkt_valid", 32'(pkt_valid), 32'd1);
        check("s1_pkt_src",   32'(pkt_src), 32'd2);
        check("s1_pkt_data",  32'(pkt_data), 32'hA5);
        check("s1_acc2",      32'(acc(2)), 32'd1);
        tick();
        check("s1_data_rd_drop", 32'(sw_if.data_rd), 32'd0);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        check("s1_popped", 32'(pkt_valid), 32'd0);

        // Five back-to-back offers, consumer stalled
        for (int i = 1; i <= 5; i++) begin
            offer(2'd1, 8'(i));
            tick();
            check($sformatf("s2_data_rd_%0d", i), 32'(sw_if.data_rd), (i <= 4) ? 32'd1 : 32'd0);
        end
        sw_if.valid_out = 1'b0;
        tick();
        check("s2_data_rd_idle", 32'(sw_if.data_rd), 32'd0);
        check("s2_stall",        32'(stall_cnt), 32'd1);
        check("s2_acc1",         32'(acc(1)), 32'd4);
        check("s2_head",         32'(pkt_data), 32'd1);

        // Full FIFO: pop and push in the same cycle
        offer(2'd3, 8'h77);
        pkt_ready = 1'b1;
        tick();
        sw_if.valid_out = 1'b0;
        pkt_ready = 1'b0;
        check("s3_data_rd",  32'(sw_if.data_rd), 32'd1);
        check("s3_head2",    32'(pkt_data), 32'd2);
        check("s3_acc3",     32'(acc(3)), 32'd1);
        check("s3_stall",    32'(stall_cnt), 32'd1);
        pkt_ready = 1'b1;
        check("s3_pop2", 32'(pkt_data), 32'd2);
        tick();
        check("s3_pop3", 32'(pkt_data), 32'd3);
        tick();
        check("s3_pop4", 32'(pkt_data), 32'd4);
        tick();
        check("s3_pop77",  32'(pkt_data), 32'h77);
        check("s3_src77",  32'(pkt_src), 32'd3);
        check("s3_valid77", 32'(pkt_valid), 32'd1);
        tick();
        pkt_ready = 1'b0;
        check("s3_empty", 32'(pkt_valid), 32'd0);

        // Flush with a simultaneous offer
        for (int i = 0; i < 3; i++) begin
            offer(2'd0, 8'(8'h10 + i));
            tick();
        end
        check("s4_acc0_pre", 32'(acc(0)), 32'd3);
        offer(2'd0, 8'h13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sw_if.valid_out = 1'b0;
        check("s4_data_rd", 32'(sw_if.data_rd), 32'd0);
        check("s4_valid",   32'(pkt_valid), 32'd0);
        check("s4_acc0",    32'(acc(0)), 32'd3);
        check("s4_stall",   32'(stall_cnt), 32'd1);

        // Saturation and clear-wins
        pkt_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            offer(2'd0, 8'(i));
            tick();
        end
        check("s5_acc0_max", 32'(acc(0)), 32'hF);
        offer(2'd0, 8'hEE);
        tick();
        check("s5_acc0_sat",  32'(acc(0)), 32'hF);
        check("s5_data_rd",   32'(sw_if.data_rd), 32'd1);
        stats_clr = 1'b1;
        offer(2'd0, 8'hEF);
        tick();
        stats_clr = 1'b0;
        sw_if.valid_out = 1'b0;
        check("s5_clr_acc0",  32'(acc(0)), 32'd0);
        check("s5_clr_all",   32'(acc_cnt), 32'd0);
        check("s5_clr_stall", 32'(stall_cnt), 32'd0);
        tick();
        pkt_ready = 1'b0;
        check("s5_drained", 32'(pkt_valid), 32'd0);

        // Asynchronous reset while in ACK
        offer(2'd2, 8'h5A);
        tick();
        sw_if.valid_out = 1'b0;
        check("s6_ack", 32'(sw_if.data_rd), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_async_data_rd",   32'(sw_if.data_rd), 32'd0);
        check("s6_async_pkt_valid", 32'(pkt_valid), 32'd0);
        check("s6_async_acc2",      32'(acc(2)), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        offer(2'd2, 8'hA5);
        tick();
        sw_if.valid_out = 1'b0;
        check("s6_data_rd",  32'(sw_if.data_rd), 32'd1);
        check("s6_pkt_src",  32'(pkt_src), 32'd2);
        check("s6_pkt_data", 32'(pkt_data), 32'hA5);
        check("s6_acc2",     32'(acc(2)), 32'd1);
        tick();
        check("s6_data_rd_drop", 32'(sw_if.data_rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
